// File: rtl/poly5_sweep.sv
`default_nettype none
// ============================================================================
// Module   : poly5_sweep
// Brief    : Sweep sequencer feeding a 5th-order polynomial evaluator. Pushes
//            six Q16.16 coefficients, then an arithmetic sequence of x values,
//            and waits for every result (or a timeout) before signalling done.
//            Define POLY5_SWEEP_SAT_EN to saturate x accumulation instead of
//            wrapping.
// Revision : 1.0
// ============================================================================
module poly5_sweep #(
    parameter int TMO = 16,
    parameter int CW  = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cfg_we,
    input  logic [3:0]  cfg_addr,
    input  logic [31:0] cfg_data,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic        pushout,
    output logic [3:0]  opout,
    output logic [31:0] dataout,
    input  logic        respush
);

    localparam int TW = $clog2(TMO + 1);
    localparam logic [TW-1:0] c_tmo_last = TW'(TMO - 1);
    localparam logic [TW-1:0] c_one_tw   = TW'(1);
    localparam logic [CW-1:0] c_one_cw   = CW'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOADC = 2'd1,
        S_SWEEP = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t         r_state, w_state_n;
    logic [31:0]    r_coef [6];
    logic [31:0]    r_xstart, r_xstep, r_xacc;
    logic [CW-1:0]  r_count, r_rem, r_res;
    logic [2:0]     r_k;
    logic [TW-1:0]  r_tmr;
    logic           r_arm;
    logic           r_busy, r_done, r_err, r_push;
    logic [3:0]     r_op;
    logic [31:0]    r_data;

    logic           w_push, w_done, w_timeout;
    logic [3:0]     w_op;
    logic [31:0]    w_data, w_xnext;
    logic [32:0]    w_sum;

    assign busy    = r_busy;
    assign done    = r_done;
    assign err     = r_err;
    assign pushout = r_push;
    assign opout   = r_op;
    assign dataout = r_data;

    // Sign-extended sum exposes two's-complement overflow in bits 32/31.
    assign w_sum = {r_xacc[31], r_xacc} + {r_xstep[31], r_xstep};

    always_comb begin
        w_xnext = w_sum[31:0];
`ifdef POLY5_SWEEP_SAT_EN
        if (w_sum[32] != w_sum[31])
            w_xnext = w_sum[32] ? 32'h8000_0000 : 32'h7FFF_FFFF;
`else
        w_xnext = w_sum[31:0];
`endif
    end

    always_comb begin
        w_state_n = r_state;
        w_push    = 1'b0;
        w_op      = r_op;
        w_data    = r_data;
        w_done    = 1'b0;
        w_timeout = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start)
                    w_state_n = S_LOADC;
            end
            S_LOADC: begin
                w_push = 1'b1;
                w_op   = {1'b0, r_k};
                w_data = r_coef[r_k];
                if (r_k == 3'd5)
                    w_state_n = (r_count == '0) ? S_DRAIN : S_SWEEP;
            end
            S_SWEEP: begin
                w_push = 1'b1;
                w_op   = 4'hF;
                w_data = r_xacc;
                if (r_rem == c_one_cw)
                    w_state_n = S_DRAIN;
            end
            S_DRAIN: begin
                // The first DRAIN cycle only arms; completion is judged from the next one.
                if (!r_arm) begin
                    if (r_res == r_count) begin
                        w_done    = 1'b1;
                        w_state_n = S_IDLE;
                    end else if (!respush && r_tmr == c_tmo_last) begin
                        w_done    = 1'b1;
                        w_timeout = 1'b1;
                        w_state_n = S_IDLE;
                    end
                end
            end
            default: w_state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            for (int i = 0; i < 6; i++)
                r_coef[i] <= 32'h0001_0000;
            r_xstart <= '0;
            r_xstep  <= '0;
            r_count  <= '0;
            r_xacc   <= '0;
            r_rem    <= '0;
            r_res    <= '0;
            r_k      <= '0;
            r_tmr    <= '0;
            r_arm    <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            r_push   <= 1'b0;
            r_op     <= '0;
            r_data   <= '0;
        end else begin
            r_state <= w_state_n;
            r_push  <= w_push;
            r_op    <= w_op;
            r_data  <= w_data;
            r_done  <= w_done;
            r_busy  <= (w_state_n != S_IDLE) || w_done;

            if (r_state == S_IDLE && start) begin
                r_err  <= 1'b0;
                r_res  <= '0;
                r_xacc <= r_xstart;
                r_rem  <= r_count;
                r_k    <= '0;
            end else if (w_timeout) begin
                r_err <= 1'b1;
            end

            if (r_state == S_IDLE && cfg_we && !start) begin
                case (cfg_addr)
                    4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5: r_coef[cfg_addr[2:0]] <= cfg_data;
                    4'd8:    r_xstart <= cfg_data;
                    4'd9:    r_xstep  <= cfg_data;
                    4'd10:   r_count  <= cfg_data[CW-1:0];
                    default: ;
                endcase
            end

            if (r_state == S_LOADC)
                r_k <= r_k + 3'd1;

            if (r_state == S_SWEEP) begin
                r_xacc <= w_xnext;
                r_rem  <= r_rem - c_one_cw;
            end

            if ((r_state == S_SWEEP || r_state == S_DRAIN) && respush && r_res != r_count)
                r_res <= r_res + c_one_cw;

            if (w_state_n == S_DRAIN && r_state != S_DRAIN) begin
                r_tmr <= '0;
                r_arm <= 1'b1;
            end else if (r_state == S_DRAIN) begin
                r_arm <= 1'b0;
                r_tmr <= respush ? '0 : r_tmr + c_one_tw;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_poly5_sweep.sv
`default_nettype none
// ============================================================================
// Module   : tb_poly5_sweep
// Brief    : Self-checking bench for poly5_sweep with a loopback evaluator stub
//            and a sweep-level reference model.
// Revision : 1.0
// ============================================================================
module tb_poly5_sweep;

    localparam int TMO = 16;
    localparam int CW  = 16;

    logic        clk = 1'b0;
    logic        rst, cfg_we, start, respush;
    logic [3:0]  cfg_addr;
    logic [31:0] cfg_data;
    logic        busy, done, err, pushout;
    logic [3:0]  opout;
    logic [31:0] dataout;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int t0     = 0;

    logic [3:0]  got_op   [$];
    logic [31:0] got_data [$];
    int          done_cnt = 0;
    int          done_cyc = 0;
    logic        done_err, done_busy;
    bit          loop_en = 1'b1;
    logic        d1, d2;

    logic [31:0] m_coef [6];
    logic [31:0] m_xs, m_xst;
    int          m_cnt;

    poly5_sweep #(.TMO(TMO), .CW(CW)) dut (
        .clk      (clk),
        .rst      (rst),
        .cfg_we   (cfg_we),
        .cfg_addr (cfg_addr),
        .cfg_data (cfg_data),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .pushout  (pushout),
        .opout    (opout),
        .dataout  (dataout),
        .respush  (respush)
    );

    always #5 clk = ~clk;

    // Monitor plus evaluator stub: each x push comes back as respush two cycles later.
    initial begin
        d1 = 1'b0; d2 = 1'b0; respush = 1'b0;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (pushout === 1'b1) begin
                got_op.push_back(opout);
                got_data.push_back(dataout);
            end
            if (done === 1'b1) begin
                done_cnt++;
                done_cyc  = cyc;
                done_err  = err;
                done_busy = busy;
            end
            respush = loop_en ? d2 : 1'b0;
            d2 = d1;
            d1 = (pushout === 1'b1) && (opout === 4'hF);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired got running want finished");
        $fatal(1);
    end

    function automatic logic [31:0] model_next(input logic [31:0] x, input logic [31:0] s);
        longint a;
        logic [63:0] u;
        a = longint'($signed(x)) + longint'($signed(s));
`ifdef POLY5_SWEEP_SAT_EN
        if (a > 64'sd2147483647)  return 32'h7FFF_FFFF;
        if (a < -64'sd2147483648) return 32'h8000_0000;
`endif
        u = a;
        return u[31:0];
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 6; i++) m_coef[i] = 32'h0001_0000;
        m_xs = '0; m_xst = '0; m_cnt = 0;
    endtask

    task automatic m_write(input logic [3:0] a, input logic [31:0] d);
        if (a <= 4'd5)       m_coef[a] = d;
        else if (a == 4'd8)  m_xs = d;
        else if (a == 4'd9)  m_xst = d;
        else if (a == 4'd10) m_cnt = int'(d[CW-1:0]);
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d, input bit accepted);
        @(negedge clk);
        cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
        @(negedge clk);
        cfg_we = 1'b0;
        if (accepted) m_write(a, d);
    endtask

    task automatic start_sweep(input bit with_we, input logic [31:0] wdata);
        @(negedge clk);
        got_op.delete();
        got_data.delete();
        done_cnt = 0;
        start = 1'b1;
        cfg_we = with_we; cfg_addr = 4'd0; cfg_data = wdata;
        @(negedge clk);
        t0 = cyc;
        start = 1'b0;
        cfg_we = 1'b0;
    endtask

    task automatic finish_sweep(input string name, input bit exp_err);
        int guard = 0;
        int n = m_cnt;
        int exp_done;
        logic [31:0] x;
        while (done_cnt == 0 && guard < 400) begin
            @(negedge clk);
            guard++;
        end
        n_chk++;
        if (done_cnt == 0) begin
            n_fail++;
            $display("FAIL %s done_wait got no done want done", name);
        end
        repeat (3) @(negedge clk);

        n_chk++;
        if (got_op.size() != 6 + n) begin
            n_fail++;
            $display("FAIL %s push_count got %0d want %0d", name, got_op.size(), 6 + n);
        end
        for (int k = 0; k < 6; k++) begin
            n_chk++;
            if (k >= got_op.size() || got_op[k] !== 4'(k) || got_data[k] !== m_coef[k]) begin
                n_fail++;
                $display("FAIL %s coef%0d got op %0h data %08h want op %0h data %08h",
                         name, k, (k < got_op.size()) ? got_op[k] : 4'hx,
                         (k < got_op.size()) ? got_data[k] : 32'hx, k, m_coef[k]);
            end
        end
        x = m_xs;
        for (int i = 0; i < n; i++) begin
            n_chk++;
            if (6 + i >= got_op.size() || got_op[6+i] !== 4'hF || got_data[6+i] !== x) begin
                n_fail++;
                $display("FAIL %s x%0d got op %0h data %08h want op f data %08h",
                         name, i, (6 + i < got_op.size()) ? got_op[6+i] : 4'hx,
                         (6 + i < got_op.size()) ? got_data[6+i] : 32'hx, x);
            end
            x = model_next(x, m_xst);
        end

        exp_done = exp_err ? t0 + 6 + n + TMO : ((n == 0) ? t0 + 8 : t0 + 10 + n);
        n_chk++;
        if (done_cyc !== exp_done) begin
            n_fail++;
            $display("FAIL %s done_time got T+%0d want T+%0d", name, done_cyc - t0, exp_done - t0);
        end
        n_chk++;
        if (done_cnt !== 1 || done_err !== exp_err || done_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL %s done_flags got cnt %0d err %b busy %b want cnt 1 err %b busy 1",
                     name, done_cnt, done_err, done_busy, exp_err);
        end
        n_chk++;
        if (busy !== 1'b0 || err !== exp_err) begin
            n_fail++;
            $display("FAIL %s after_done got busy %b err %b want busy 0 err %b", name, busy, err, exp_err);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; cfg_we = 1'b0; start = 1'b0; cfg_addr = '0; cfg_data = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        m_reset();
        n_chk++;
        if (pushout !== 1'b0 || opout !== 4'h0 || dataout !== 32'h0 ||
            busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs got push %b op %0h data %08h busy %b done %b err %b want all 0",
                     pushout, opout, dataout, busy, done, err);
        end
    endtask

    task automatic test_count0();
        start_sweep(1'b0, '0);
        finish_sweep("count0", 1'b0);
    endtask

    task automatic test_basic();
        wr(4'd8, 32'h0001_0000, 1'b1);
        wr(4'd9, 32'h0000_8000, 1'b1);
        wr(4'd10, 32'd3, 1'b1);
        start_sweep(1'b0, '0);
        finish_sweep("basic", 1'b0);
    endtask

    task automatic test_timeout();
        loop_en = 1'b0;
        start_sweep(1'b0, '0);
        finish_sweep("timeout", 1'b1);
        loop_en = 1'b1;
    endtask

    task automatic test_random();
        for (int it = 0; it < 4; it++) begin
            for (int k = 0; k < 6; k++) wr(4'(k), $urandom, 1'b1);
            wr(4'd8, $urandom, 1'b1);
            wr(4'd9, $urandom, 1'b1);
            wr(4'd10, 32'($urandom_range(1, 6)), 1'b1);
            start_sweep(1'b0, '0);
            finish_sweep($sformatf("random%0d", it), 1'b0);
        end
    endtask

    task automatic test_cfg_drop();
        wr(4'd10, 32'd3, 1'b1);
        start_sweep(1'b1, 32'h1234_5678);
        repeat (7) @(negedge clk);
        wr(4'd0, 32'h1234_5678, 1'b0);
        finish_sweep("drop_with_start", 1'b0);
        start_sweep(1'b0, '0);
        finish_sweep("drop_in_sweep", 1'b0);
    endtask

    task automatic test_overflow();
        wr(4'd8, 32'h7FFF_0000, 1'b1);
        wr(4'd9, 32'h0001_0000, 1'b1);
        wr(4'd10, 32'd3, 1'b1);
        start_sweep(1'b0, '0);
        finish_sweep("overflow", 1'b0);
    endtask

    task automatic test_rst_mid();
        wr(4'd0, 32'h1234_5678, 1'b1);
        wr(4'd10, 32'd5, 1'b1);
        start_sweep(1'b0, '0);
        repeat (8) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_chk++;
        if (pushout !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || opout !== 4'h0 || dataout !== 32'h0) begin
            n_fail++;
            $display("FAIL rst_mid_outputs got push %b busy %b done %b op %0h data %08h want all 0",
                     pushout, busy, done, opout, dataout);
        end
        m_reset();
        repeat (2) @(negedge clk);
        start_sweep(1'b0, '0);
        finish_sweep("after_rst", 1'b0);
    endtask

    initial begin
        test_reset();
        test_count0();
        test_basic();
        test_timeout();
        test_random();
        test_cfg_drop();
        test_overflow();
        test_rst_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/poly5_sweep.md
# poly5_sweep

Command sequencer upstream of the 5th-order polynomial evaluator. It holds six Q16.16 coefficient shadows and sweep parameters written by a host. On `start` it pushes the coefficients into the evaluator, then streams an arithmetic sequence of x values, one per cycle. It counts the evaluator's result strobes, and signals `done`, or `err` on timeout, when the sweep has fully drained.

## Interface
Parameters:
- `TMO`, default 16: cycles with no returned result tolerated in DRAIN before timeout.
- `CW`, default 16: width of sweep count register.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `cfg_we`  in  1  host register write strobe.
- `cfg_addr`  in  4  register select: 0–5 coeff a0–a5, 8 x start, 9 x step, 10 count.
- `cfg_data`  in  32  write data (count uses low `CW` bits).
- `start`  in  1  single-cycle sweep request.
- `busy`  out  1  sweep in progress.
- `done`  out  1  one-cycle completion pulse.
- `err`  out  1  timeout flag, valid with `done`, held until next accepted `start`.
- `pushout`  out  1  push strobe to evaluator.
- `opout`  out  4  evaluator opcode: 0–5 coefficient, 15 x value.
- `dataout`  out  32  evaluator data.
- `respush`  in  1  evaluator result strobe (its push output).

## Operation
- Registers reset to: a0–a5 = 0x00010000, xstart = 0, xstep = 0, count = 0.
- `cfg_we` writes are accepted only in IDLE. Writes while `busy` are dropped. If `cfg_we` and `start` are high in the same IDLE cycle, `start` wins and the write is dropped.
- The FSM has four states: IDLE, LOADC, SWEEP, DRAIN.
  - IDLE: on `start`, go to LOADC. Clear `err`, clear the result counter, load the x accumulator with xstart and the remaining counter with count. `start` outside IDLE is ignored.
  - LOADC: six cycles driving `pushout`=1, `opout`=k, `dataout`=a_k for k = 0..5 in order. Then go to SWEEP, or to DRAIN if count = 0.
  - SWEEP: each cycle drive `pushout`=1, `opout`=15, `dataout`=x_acc. Then x_acc ← x_acc + xstep (32-bit two's complement) and remaining ← remaining − 1. After the last x push, go to DRAIN.
  - DRAIN: wait until results received == count, then pulse `done` with `err`=0 and go to IDLE.
- The idle timer starts when the FSM enters DRAIN and is cleared on every `respush`. If it reaches `TMO` before all results arrive, pulse `done`, set `err`=1 and go to IDLE.
- Result counting:
  - `respush` is counted in SWEEP and DRAIN only.
  - `respush` in IDLE or LOADC is ignored.
  - The counter saturates at count, so excess results are not counted.
- `busy` is 1 from the cycle after `start` is accepted through the cycle `done` is high.
- `pushout`=0 in IDLE and DRAIN. `opout` and `dataout` hold their last values there.

## Timing
- All outputs are registered. Reset values: `pushout`=0, `opout`=0, `dataout`=0, `busy`=0, `done`=0, `err`=0.
- `start` sampled high at edge T:
  - edges T+1..T+6 present the coefficient pushes;
  - edges T+7..T+6+count present the x pushes.
- No backpressure: the evaluator accepts one push per cycle.
- The evaluator returns each result 2 cycles after its x push. In the normal case, `done` rises 1 cycle after the last `respush` is sampled.
- count = 0: `done` rises at T+8 with no x push.
- `rst` mid-sweep: next edge returns to IDLE, all outputs to reset values, all registers to reset values. No partial push is completed.

## Configuration
- `POLY5_SWEEP_SAT_EN` defined: x accumulation saturates.
  - Positive overflow clamps to 0x7FFFFFFF; negative overflow clamps to 0x80000000.
  - Once clamped, the value repeats for the remaining pushes.
- Not defined: x accumulation wraps modulo 2^32.

## Test plan
- Reset, then start with count = 0 -> six pushes with opout 0..5, each with dataout 0x00010000; no op-15 push; `done`=1, `err`=0 at T+8.
- Write xstart = 0x00010000, xstep = 0x00008000, count = 3; start; loop `respush` back 2 cycles after each push -> x pushes 0x00010000, 0x00018000, 0x00020000; `done` once, `err`=0.
- Same as the previous test but never assert `respush` -> `done` and `err`=1 exactly `TMO` cycles after DRAIN entry; `busy` drops.
- `cfg_we` to a0 with 0x12345678 during SWEEP, and `cfg_we` coincident with `start` -> both writes dropped; next sweep pushes a0 = original value.
- xstart = 0x7FFF0000, xstep = 0x00010000, count = 3 -> without macro: 0x7FFF0000, 0x80000000, 0x80010000; with `POLY5_SWEEP_SAT_EN`: 0x7FFF0000, 0x7FFFFFFF, 0x7FFFFFFF.
- Assert `rst` for one cycle mid-SWEEP -> `pushout`, `busy`, `done` go to 0 next cycle; a0 reads back as 0x00010000 on the next sweep.
